// File: rtl/fetch_controller.sv
// fetch_controller
//
// Instruction-fetch sequencer for the IF stage. Owns the program counter,
// drives the instruction memory address, and registers the fetched word and
// its PC into the IF/ID boundary. Handles hazard stalls and branch/jump
// redirects, and time-shares the instruction memory with a program loader
// that writes words while fetch is suspended.
//
// Ports
//   clk, reset          sole clock (rising edge), synchronous active-high reset
//   stall               hold pc and IF outputs
//   redirect_valid      taken branch/jump; redirect_target is the new pc
//   redirect_target     new pc, bits [1:0] are forced to zero
//   load_req/addr/data  loader word to write, held until load_ack
//   load_ack            loader word accepted this cycle (combinational)
//   load_err            sticky out-of-range loader address flag
//   load_count          words written in the current/last load session
//   loading             high while in the LOAD state (this is the FSM state)
//   imem_address/we/wdata  instruction memory address and write port
//   imem_instruction    memory read data, combinational from imem_address
//   if_instruction/if_pc/if_valid  registered IF/ID boundary
//
// Loader handshake: the loader raises load_req with load_addr/load_data and
// holds all three stable until it sees load_ack high in a cycle; the word is
// taken at the rising edge that ends that cycle. The loader may then present
// the next word immediately (one word per cycle) or drop load_req to end the
// session. A load_req seen while fetching only opens the session; the first
// ack comes in the following cycle.

module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ack,
  output logic        load_err,
  output logic [15:0] load_count,
  output logic        loading,
  output logic [31:0] imem_address,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifi_q, ifi_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        ifv_q, ifv_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;

  logic [31:0] word_idx;
  logic        in_range;

  assign word_idx = {2'b00, load_addr[31:2]};
  assign in_range = (word_idx < 32'(DEPTH_WORDS));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifi_d        = ifi_q;
    ifpc_d       = ifpc_q;
    ifv_d        = ifv_q;
    err_d        = err_q;
    count_d      = count_q;
    load_ack     = 1'b0;
    imem_we      = 1'b0;
    imem_address = pc_q;
    imem_wdata   = 32'h0;

    case (state_q)
      RUN: begin
        if (load_req) begin
          // Opening a session: no write yet, and any redirect is dropped.
          state_d = LOAD;
          ifv_d   = 1'b0;
          count_d = 16'h0000;
        end else if (redirect_valid) begin
          // Redirect wins over stall; the word currently fetched is squashed.
          pc_d  = {redirect_target[31:2], 2'b00};
          ifv_d = 1'b0;
        end else if (!stall) begin
          ifi_d  = imem_instruction;
          ifpc_d = pc_q;
          ifv_d  = 1'b1;
          pc_d   = pc_q + 32'd4;
        end
      end

      LOAD: begin
        imem_address = load_addr;
        imem_wdata   = load_data;
        if (load_req) begin
          // A reset in this cycle aborts the session, so nothing is
          // acknowledged or written.
          load_ack = !reset;
          if (in_range) begin
            imem_we = !reset;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ifi_q   <= 32'h0;
      ifpc_q  <= 32'h0;
      ifv_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifi_q   <= ifi_d;
      ifpc_q  <= ifpc_d;
      ifv_q   <= ifv_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign loading        = (state_q == LOAD);
  assign load_err       = err_q;
  assign load_count     = count_q;
  assign if_instruction = ifi_q;
  assign if_pc          = ifpc_q;
  assign if_valid       = ifv_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios with literal
// expectations, then randomized fetch/stall/redirect/load/reset traffic
// checked every cycle against a behavioural model.

module tb_fetch_controller;

  localparam int          DEPTH   = 64;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        load_req = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;
  logic        load_ack, load_err, loading, imem_we, if_valid;
  logic [15:0] load_count;
  logic [31:0] imem_address, imem_wdata, imem_instruction, if_instruction, if_pc;

  fetch_controller #(.RESET_PC(RST_PC), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .load_err(load_err), .load_count(load_count),
    .loading(loading), .imem_address(imem_address), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .imem_instruction(imem_instruction),
    .if_instruction(if_instruction), .if_pc(if_pc), .if_valid(if_valid)
  );

  // ---------------- instruction memory (environment) ----------------
  logic [31:0] mem [DEPTH];
  assign imem_instruction = mem[imem_address[7:2]];
  always @(posedge clk) if (imem_we) mem[imem_address[7:2]] <= imem_wdata;

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [DEPTH];
  logic        m_ready = 1'b0;
  logic        m_loading, m_ifv, m_err;
  logic [31:0] m_pc, m_ifi, m_ifpc;
  logic [15:0] m_count;

  always @(posedge clk) begin
    if (reset) begin
      m_loading = 1'b0; m_pc = RST_PC; m_ifv = 1'b0; m_ifi = 0; m_ifpc = 0;
      m_err = 1'b0; m_count = 0; m_ready = 1'b1;
    end else if (m_ready) begin
      if (!m_loading) begin
        if (load_req) begin
          m_loading = 1'b1; m_ifv = 1'b0; m_count = 0;
        end else if (redirect_valid) begin
          m_pc = redirect_target & 32'hFFFF_FFFC; m_ifv = 1'b0;
        end else if (!stall) begin
          m_ifi = ref_mem[m_pc[7:2]]; m_ifpc = m_pc; m_ifv = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end else begin
        if (load_req) begin
          if ((load_addr / 4) < DEPTH) begin
            ref_mem[load_addr[7:2]] = load_data;
            if (m_count != 16'hFFFF) m_count = m_count + 1;
          end else m_err = 1'b1;
        end else begin
          m_loading = 1'b0; m_pc = RST_PC;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int ack_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual 0x%08h required 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_ack === 1'b1) ack_total++;
    if (m_ready) begin
      logic exp_ack, exp_we;
      exp_ack = !reset && m_loading && load_req;
      exp_we  = exp_ack && ((load_addr / 4) < DEPTH);
      check("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
      check("if_pc", if_pc, m_ifpc);
      check("if_instruction", if_instruction, m_ifi);
      check("loading", {31'b0, loading}, {31'b0, m_loading});
      check("load_err", {31'b0, load_err}, {31'b0, m_err});
      check("load_count", {16'b0, load_count}, {16'b0, m_count});
      check("imem_address", imem_address, m_loading ? load_addr : m_pc);
      check("load_ack", {31'b0, load_ack}, {31'b0, exp_ack});
      check("imem_we", {31'b0, imem_we}, {31'b0, exp_we});
      if (exp_we) check("imem_wdata", imem_wdata, load_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; load_req = 1'b0;
  endtask

  // Full loader session: request, one word per acked cycle, then release.
  task automatic do_load(input int n, input logic [31:0] base, input logic [31:0] dbase,
                         input bit rnd);
    idle_inputs();
    for (int i = 0; i < n; i++) begin
      load_req  = 1'b1;
      load_addr = rnd ? $urandom_range(0, 4 * DEPTH + 16) : base + 32'(4 * i);
      load_data = rnd ? $urandom : dbase + 32'(i);
      tick();
      if (i == 0) tick(); // entry cycle: no ack yet
    end
    load_req = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = (i < 4) ? 32'(8'h11 * (i + 1)) : $urandom;
      mem[i] = w; ref_mem[i] = w;
    end

    // Reset and first fetches
    reset = 1'b1; idle_inputs();
    tick(); tick();
    reset = 1'b0;
    check("lit_reset_if_valid", {31'b0, if_valid}, 32'd0);
    check("lit_reset_count", {16'b0, load_count}, 32'd0);
    check("lit_reset_pc", imem_address, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("lit_fetch_pc", if_pc, 32'(4 * k));
      check("lit_fetch_instr", if_instruction, 32'(8'h11 * (k + 1)));
    end

    // Stall 3 cycles with pc = 8
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lit_stall_if_pc", if_pc, 32'h4);
      check("lit_stall_pc", imem_address, 32'h8);
    end
    stall = 1'b0;
    for (int k = 2; k < 4; k++) begin
      tick();
      check("lit_resume_pc", if_pc, 32'(4 * k));
      check("lit_resume_instr", if_instruction, 32'(8'h11 * (k + 1)));
    end

    // Redirect together with stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0042;
    tick();
    idle_inputs();
    check("lit_redir_pc", imem_address, 32'h40);
    check("lit_redir_bubble", {31'b0, if_valid}, 32'd0);
    tick();
    check("lit_redir_if_pc", if_pc, 32'h40);
    check("lit_redir_valid", {31'b0, if_valid}, 32'd1);

    // Load 4 words at 0x0..0xC
    begin
      int a0;
      a0 = ack_total;
      do_load(4, 32'h0, 32'hA0, 1'b0);
      check("lit_load_acks", 32'(ack_total - a0), 32'd4);
      check("lit_load_count", {16'b0, load_count}, 32'd4);
      check("lit_load_loading", {31'b0, loading}, 32'd0);
      check("lit_load_restart_pc", imem_address, RST_PC);
      tick();
      check("lit_load_fetch_pc", if_pc, 32'h0);
      check("lit_load_fetch_instr", if_instruction, 32'hA0);
    end

    // Out-of-range load word
    load_req = 1'b1; load_addr = 32'(4 * DEPTH); load_data = 32'hDEAD_BEEF;
    tick();
    check("lit_oor_ack", {31'b0, load_ack}, 32'd1);
    check("lit_oor_we", {31'b0, imem_we}, 32'd0);
    tick();
    load_req = 1'b0;
    check("lit_oor_err", {31'b0, load_err}, 32'd1);
    check("lit_oor_count", {16'b0, load_count}, 32'd0);
    tick(); tick();
    check("lit_oor_err_sticky", {31'b0, load_err}, 32'd1);

    // Reset mid-load after 2 writes
    load_req = 1'b1; load_addr = 32'h10; load_data = 32'h5555_0001;
    tick(); tick();
    load_addr = 32'h14; load_data = 32'h5555_0002;
    tick();
    load_addr = 32'h18; load_data = 32'h5555_0003;
    check("lit_midload_count2", {16'b0, load_count}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0; load_req = 1'b0;
    check("lit_midload_loading", {31'b0, loading}, 32'd0);
    check("lit_midload_count", {16'b0, load_count}, 32'd0);
    check("lit_midload_pc", imem_address, RST_PC);
    check("lit_midload_ack", {31'b0, load_ack}, 32'd0);
    check("lit_midload_err_clr", {31'b0, load_err}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_load($urandom_range(1, 5), 32'h0, 32'h0, 1'b1);
      end else if (r < 5) begin
        idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
      end else begin
        stall           = ($urandom_range(0, 9) < 3);
        redirect_valid  = ($urandom_range(0, 9) == 0);
        redirect_target = $urandom_range(0, 255);
        load_addr       = $urandom;
        tick();
      end
    end
    idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
